mem_port_arbiter: RTL and testbench

Arbitrates a single-ported unified instruction/data RAM between the pipeline's instruction-fetch requester and its memory-stage requester (load/store). It sequences each RAM access over a fixed multi-cycle latency, returns read data with a one-cycle valid pulse, and drives stall signals to the hazard-detection logic so IF or MEM holds while its access is pending. On contention it grants round-robin.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the shared RAM and the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  IfReq;
  logic [ADDR_WIDTH-1:0] IfAddress;
  logic [DATA_WIDTH-1:0] IfData;
  logic                  IfValid;
  logic                  MemReq;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemReadData;
  logic                  MemValid;
  logic                  StallIF;
  logic                  StallMEM;
  logic                  RamEn;
  logic                  RamWe;
  logic [ADDR_WIDTH-1:0] RamAddr;
  logic [DATA_WIDTH-1:0] RamWdata;
  logic [DATA_WIDTH-1:0] RamRdata;

  modport slave (
    input  IfReq, IfAddress, MemReq, MemWrite, MemAddress, MemWriteData, RamRdata,
    output IfData, IfValid, MemReadData, MemValid, StallIF, StallMEM,
           RamEn, RamWe, RamAddr, RamWdata
  );

  modport master (
    output IfReq, IfAddress, MemReq, MemWrite, MemAddress, MemWriteData, RamRdata,
    input  IfData, IfValid, MemReadData, MemValid, StallIF, StallMEM,
           RamEn, RamWe, RamAddr, RamWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between instruction fetch
// and the memory stage, with fixed multi-cycle access latency and stall outputs.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input logic               Clk,
  input logic               Rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  owner;
  logic                  last_grant;
  logic [CNT_W-1:0]      cnt;

  logic                  grant;
  logic                  grant_owner;
  logic                  grant_we;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_wdata;

  logic [DATA_WIDTH-1:0] if_data;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and grant decision; in RESP the finishing owner is ignored
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_owner = OWN_IF;
    unique case (state)
      ST_IDLE: begin
        if (bus.IfReq && bus.MemReq) begin
          grant       = 1'b1;
          grant_owner = ~last_grant;
        end else if (bus.IfReq || bus.MemReq) begin
          grant       = 1'b1;
          grant_owner = bus.MemReq ? OWN_MEM : OWN_IF;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        if (owner == OWN_IF && bus.MemReq) begin
          grant       = 1'b1;
          grant_owner = OWN_MEM;
        end else if (owner == OWN_MEM && bus.IfReq) begin
          grant       = 1'b1;
          grant_owner = OWN_IF;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (grant) state_nxt = ST_ACCESS;
  end

  // Request fields of the winner; requesters hold these stable until Valid
  always_comb begin
    grant_we    = 1'b0;
    grant_addr  = bus.IfAddress;
    grant_wdata = '0;
    if (grant_owner == OWN_MEM) begin
      grant_we    = bus.MemWrite;
      grant_addr  = bus.MemAddress;
      grant_wdata = bus.MemWriteData;
    end
  end

  // Datapath: RAM drive held for the whole access, result capture on its last cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      cnt        <= '0;
      if_data    <= '0;
      if_valid   <= 1'b0;
      mem_rdata  <= '0;
      mem_valid  <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if (grant) begin
        owner      <= grant_owner;
        last_grant <= grant_owner;
        cnt        <= CNT_W'(MEM_LATENCY - 1);
        ram_en     <= 1'b1;
        ram_we     <= grant_we;
        ram_addr   <= grant_addr;
        ram_wdata  <= grant_wdata;
      end else if (state == ST_ACCESS) begin
        if (cnt == '0) begin
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          if (owner == OWN_IF) begin
            if_data  <= bus.RamRdata;
            if_valid <= 1'b1;
          end else begin
            mem_valid <= 1'b1;
            if (!ram_we) mem_rdata <= bus.RamRdata;
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  assign bus.IfData      = if_data;
  assign bus.IfValid     = if_valid;
  assign bus.MemReadData = mem_rdata;
  assign bus.MemValid    = mem_valid;
  assign bus.RamEn       = ram_en;
  assign bus.RamWe       = ram_we;
  assign bus.RamAddr     = ram_addr;
  assign bus.RamWdata    = ram_wdata;
  assign bus.StallIF     = bus.IfReq & ~if_valid;
  assign bus.StallMEM    = bus.MemReq & ~mem_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2) with a small RAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
module tb_mem_port_arbiter;
  logic Clk;
  logic Rst;
  int   vectors;
  int   miscompares;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: word-indexed, write on the enabled edge, read combinationally
  logic [31:0] ram [0:255];
  always @(posedge Clk) begin
    if (bus.RamEn && bus.RamWe) ram[bus.RamAddr[9:2]] <= bus.RamWdata;
  end
  assign bus.RamRdata = bus.RamEn ? ram[bus.RamAddr[9:2]] : 32'h0;

  // Requests must stay up until their Valid pulse
  logic if_pend  = 1'b0;
  logic mem_pend = 1'b0;
  always @(posedge Clk) begin
    if (!Rst) begin
      assert (!(if_pend && !bus.IfReq)) else $error("protocol violation: IfReq dropped before IfValid");
      assert (!(mem_pend && !bus.MemReq)) else $error("protocol violation: MemReq dropped before MemValid");
    end
    if_pend  <= bus.IfReq & ~bus.IfValid;
    mem_pend <= bus.MemReq & ~bus.MemValid;
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IfReq        = 1'b0;
    bus.IfAddress    = '0;
    bus.MemReq       = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
  endtask

  // Leaves the caller at cycle 0: reset already released, state IDLE
  task automatic do_reset();
    Rst = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    idle_inputs();
    bus.IfReq = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge Clk);
    vectors++;
    if ({bus.RamEn, bus.RamWe, bus.IfValid, bus.MemValid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.RamEn, bus.RamWe, bus.IfValid, bus.MemValid});
    end
    vectors++;
    if ({bus.RamAddr, bus.RamWdata, bus.IfData, bus.MemReadData} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h exp=0", {bus.RamAddr, bus.RamWdata, bus.IfData, bus.MemReadData});
    end
    vectors++;
    if ({bus.StallIF, bus.StallMEM} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_stall got=%b exp=10", {bus.StallIF, bus.StallMEM});
    end
    next_cycle();
  endtask

  task automatic test_lone_fetch();
    do_reset();
    bus.IfReq     = 1'b1;
    bus.IfAddress = 32'h40;
    for (int c = 0; c < 4; c++) begin
      logic exp_en;
      @(negedge Clk);
      exp_en = (c == 1 || c == 2);
      vectors++;
      if (bus.RamEn !== exp_en || bus.RamWe !== 1'b0 || bus.RamAddr !== (exp_en ? 32'h40 : 32'h0)) begin
        miscompares++;
        $display("FAIL lone_fetch_ram c=%0d got en=%b we=%b addr=%h exp en=%b", c, bus.RamEn, bus.RamWe, bus.RamAddr, exp_en);
      end
      vectors++;
      if (bus.IfValid !== (c == 3) || bus.StallIF !== (c != 3)) begin
        miscompares++;
        $display("FAIL lone_fetch_valid c=%0d got valid=%b stall=%b exp valid=%b", c, bus.IfValid, bus.StallIF, c == 3);
      end
      if (c == 3) begin
        vectors++;
        if (bus.IfData !== 32'h2002000A) begin
          miscompares++;
          $display("FAIL lone_fetch_data got=%h exp=2002000a", bus.IfData);
        end
      end
      next_cycle();
    end
    bus.IfReq = 1'b0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.MemReq     = 1'b1;
    bus.MemAddress = 32'h10;
    bus.IfReq      = 1'b1;
    bus.IfAddress  = 32'h44;
    for (int c = 0; c < 7; c++) begin
      logic        exp_en;
      logic [31:0] exp_addr;
      if (c == 4) bus.MemReq = 1'b0;
      @(negedge Clk);
      exp_en   = (c == 1 || c == 2 || c == 4 || c == 5);
      exp_addr = (c == 1 || c == 2) ? 32'h10 : (exp_en ? 32'h44 : 32'h0);
      vectors++;
      if (bus.RamEn !== exp_en || bus.RamAddr !== exp_addr) begin
        miscompares++;
        $display("FAIL simult_ram c=%0d got en=%b addr=%h exp en=%b addr=%h", c, bus.RamEn, bus.RamAddr, exp_en, exp_addr);
      end
      vectors++;
      if (bus.MemValid !== (c == 3) || bus.IfValid !== (c == 6)) begin
        miscompares++;
        $display("FAIL simult_valid c=%0d got mv=%b iv=%b", c, bus.MemValid, bus.IfValid);
      end
      vectors++;
      if (bus.StallIF !== (c < 6) || bus.StallMEM !== (c < 3)) begin
        miscompares++;
        $display("FAIL simult_stall c=%0d got sif=%b smem=%b", c, bus.StallIF, bus.StallMEM);
      end
      if (c == 3) begin
        vectors++;
        if (bus.MemReadData !== 32'h11112222) begin
          miscompares++;
          $display("FAIL simult_mdata got=%h exp=11112222", bus.MemReadData);
        end
      end
      if (c == 6) begin
        vectors++;
        if (bus.IfData !== 32'h33334444) begin
          miscompares++;
          $display("FAIL simult_idata got=%h exp=33334444", bus.IfData);
        end
      end
      next_cycle();
    end
    bus.IfReq = 1'b0;
    next_cycle();
  endtask

  task automatic test_contention();
    do_reset();
    bus.MemReq     = 1'b1;
    bus.MemAddress = 32'h20;
    bus.IfReq      = 1'b1;
    bus.IfAddress  = 32'h40;
    for (int c = 0; c < 19; c++) begin
      int          ph;
      logic        exp_en;
      logic [31:0] exp_addr;
      if (c == 16) bus.MemReq = 1'b0;
      @(negedge Clk);
      ph       = c % 6;
      exp_en   = (ph == 1 || ph == 2 || ph == 4 || ph == 5);
      exp_addr = (ph == 1 || ph == 2) ? 32'h20 : (exp_en ? 32'h40 : 32'h0);
      vectors++;
      if (bus.RamEn !== exp_en || bus.RamAddr !== exp_addr) begin
        miscompares++;
        $display("FAIL contention_grant c=%0d got en=%b addr=%h exp en=%b addr=%h", c, bus.RamEn, bus.RamAddr, exp_en, exp_addr);
      end
      vectors++;
      if (bus.MemValid !== (ph == 3) || bus.IfValid !== (c > 0 && ph == 0)) begin
        miscompares++;
        $display("FAIL contention_valid c=%0d got mv=%b iv=%b", c, bus.MemValid, bus.IfValid);
      end
      next_cycle();
    end
    bus.IfReq = 1'b0;
    next_cycle();
  endtask

  task automatic test_store();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      logic exp_en;
      logic exp_we;
      if (c == 0) begin
        bus.MemReq = 1'b1; bus.MemWrite = 1'b0; bus.MemAddress = 32'h20;
      end
      if (c == 4) bus.MemReq = 1'b0;
      if (c == 5) begin
        bus.MemReq = 1'b1; bus.MemWrite = 1'b1; bus.MemAddress = 32'h10;
        bus.MemWriteData = 32'hDEADBEEF;
      end
      if (c == 9) begin
        bus.MemReq = 1'b0; bus.MemWrite = 1'b0; bus.MemWriteData = '0;
      end
      if (c == 10) bus.MemReq = 1'b1;
      @(negedge Clk);
      exp_en = (c == 1 || c == 2 || c == 6 || c == 7 || c == 11 || c == 12);
      exp_we = (c == 6 || c == 7);
      vectors++;
      if (bus.RamEn !== exp_en || bus.RamWe !== exp_we || bus.RamWdata !== (exp_we ? 32'hDEADBEEF : 32'h0)) begin
        miscompares++;
        $display("FAIL store_ram c=%0d got en=%b we=%b wdata=%h exp en=%b we=%b", c, bus.RamEn, bus.RamWe, bus.RamWdata, exp_en, exp_we);
      end
      vectors++;
      if (bus.MemValid !== (c == 3 || c == 8 || c == 13)) begin
        miscompares++;
        $display("FAIL store_valid c=%0d got=%b", c, bus.MemValid);
      end
      if (c == 8) begin
        vectors++;
        if (bus.MemReadData !== 32'h55AA55AA) begin
          miscompares++;
          $display("FAIL store_keeps_rdata got=%h exp=55aa55aa", bus.MemReadData);
        end
      end
      if (c == 13) begin
        vectors++;
        if (bus.MemReadData !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL store_readback got=%h exp=deadbeef", bus.MemReadData);
        end
      end
      next_cycle();
    end
    bus.MemReq = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.IfReq     = 1'b1;
    bus.IfAddress = 32'h44;
    for (int c = 0; c < 6; c++) begin
      logic exp_en;
      Rst = (c == 1);
      @(negedge Clk);
      exp_en = (c == 1 || c == 3 || c == 4);
      vectors++;
      if (bus.RamEn !== exp_en || bus.IfValid !== (c == 5)) begin
        miscompares++;
        $display("FAIL reset_mid_access c=%0d got en=%b iv=%b exp en=%b iv=%b", c, bus.RamEn, bus.IfValid, exp_en, c == 5);
      end
      next_cycle();
    end
    Rst = 1'b0;
    bus.IfReq = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back_same();
    do_reset();
    bus.IfReq     = 1'b1;
    bus.IfAddress = 32'h40;
    for (int c = 0; c < 9; c++) begin
      logic exp_en;
      if (c == 8) bus.IfReq = 1'b0;
      @(negedge Clk);
      exp_en = (c == 1 || c == 2 || c == 5 || c == 6);
      vectors++;
      if (bus.RamEn !== exp_en || bus.IfValid !== (c == 3 || c == 7)) begin
        miscompares++;
        $display("FAIL held_request c=%0d got en=%b iv=%b exp en=%b", c, bus.RamEn, bus.IfValid, exp_en);
      end
      next_cycle();
    end
    next_cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4]  = 32'h11112222;
    ram[8]  = 32'h55AA55AA;
    ram[16] = 32'h2002000A;
    ram[17] = 32'h33334444;
    #1;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_contention();
    test_store();
    test_reset_mid_access();
    test_back_to_back_same();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
